// File: rtl/k_and_s_pkg.sv
// Shared K&S processor types: the decoded opcode set passed from fetch/decode to control_unit.
package k_and_s_pkg;

    typedef enum logic [3:0] {
        I_NOP,
        I_LOAD,
        I_STORE,
        I_MOVE,
        I_ADD,
        I_SUB,
        I_AND,
        I_OR,
        I_BRANCH,
        I_BZERO,
        I_BNZERO,
        I_BNEG,
        I_BNNEG,
        I_BOV,
        I_BNOV,
        I_HALT
    } decoded_instruction_type;

endpackage

// File: rtl/fetch_decode_unit.sv
// K&S datapath front end: PC, IR and flags registers, RAM address mux and IR decode.
// Optional FETCH_ILLEGAL_TRAP_EN: undefined opcodes decode to I_HALT and set a sticky illegal_op.
module fetch_decode_unit
    import k_and_s_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    branch,
    input  logic                    addr_sel,
    input  logic                    flags_reg_enable,
    input  logic [DATA_W-1:0]       ram_rdata,
    input  logic                    alu_zero,
    input  logic                    alu_neg,
    input  logic                    alu_uovf,
    input  logic                    alu_sovf,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [ADDR_W-1:0]       pc_out,
    output decoded_instruction_type decoded_instruction,
    output logic [1:0]              a_addr,
    output logic [1:0]              b_addr,
    output logic [1:0]              c_addr,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow
`ifdef FETCH_ILLEGAL_TRAP_EN
    ,
    output logic                    illegal_op
`endif
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [3:0]        flags_q, flags_d;
    logic              unused_ir7;

`ifdef FETCH_ILLEGAL_TRAP_EN
    logic opcode_legal;
    logic illegal_q, illegal_d;
`endif

    // Branch target uses the IR held before this edge, even if ir_enable loads a new word.
    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        flags_d = flags_q;
        if (pc_enable) begin
            pc_d = branch ? ir_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
        end
        if (ir_enable) begin
            ir_d = ram_rdata;
        end
        if (flags_reg_enable) begin
            flags_d = {alu_zero, alu_neg, alu_uovf, alu_sovf};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            ir_q    <= '0;
            flags_q <= '0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        decoded_instruction = I_NOP;
        a_addr              = 2'd0;
        b_addr              = 2'd0;
        c_addr              = 2'd0;
`ifdef FETCH_ILLEGAL_TRAP_EN
        opcode_legal        = 1'b1;
`endif
        case (ir_q[15:8])
            8'h00: decoded_instruction = I_NOP;
            8'h01: decoded_instruction = I_BRANCH;
            8'h02: decoded_instruction = I_BZERO;
            8'h03: decoded_instruction = I_BNEG;
            8'h05: decoded_instruction = I_BOV;
            8'h0A: decoded_instruction = I_BNZERO;
            8'h0B: decoded_instruction = I_BNNEG;
            8'h0D: decoded_instruction = I_BNOV;
            8'h81: begin
                decoded_instruction = I_LOAD;
                c_addr              = ir_q[6:5];
            end
            8'h82: begin
                decoded_instruction = I_STORE;
                a_addr              = ir_q[6:5];
            end
            8'h91: begin
                decoded_instruction = I_MOVE;
                c_addr              = ir_q[3:2];
                a_addr              = ir_q[1:0];
                b_addr              = ir_q[1:0];
            end
            8'hA1, 8'hA2, 8'hA3, 8'hA4: begin
                unique case (ir_q[9:8])
                    2'b01:   decoded_instruction = I_ADD;
                    2'b10:   decoded_instruction = I_SUB;
                    2'b11:   decoded_instruction = I_AND;
                    default: decoded_instruction = I_OR;
                endcase
                c_addr = ir_q[5:4];
                a_addr = ir_q[3:2];
                b_addr = ir_q[1:0];
            end
            8'hFF: decoded_instruction = I_HALT;
            default: begin
`ifdef FETCH_ILLEGAL_TRAP_EN
                decoded_instruction = I_HALT;
                opcode_legal        = 1'b0;
`else
                decoded_instruction = I_NOP;
`endif
            end
        endcase
    end

`ifdef FETCH_ILLEGAL_TRAP_EN
    assign illegal_d = illegal_q | ~opcode_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal_op = illegal_q;
`endif

    assign unused_ir7        = ir_q[7];
    assign ram_addr          = addr_sel ? ir_q[ADDR_W-1:0] : pc_q;
    assign pc_out            = pc_q;
    assign zero_op           = flags_q[3];
    assign neg_op            = flags_q[2];
    assign unsigned_overflow = flags_q[1];
    assign signed_overflow   = flags_q[0];

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Scoreboard bench for fetch_decode_unit: directed test-plan sequence plus randomized traffic
// checked against a table-driven reference model.
module tb_fetch_decode_unit;
    import k_and_s_pkg::*;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;

    localparam logic [7:0] OP_CODE [16] = '{
        8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h0A, 8'h0B, 8'h0D,
        8'h81, 8'h82, 8'h91, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hFF
    };
    localparam decoded_instruction_type OP_KIND [16] = '{
        I_NOP, I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNZERO, I_BNNEG, I_BNOV,
        I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR, I_HALT
    };

    logic clk, rst_n;
    logic pc_enable, ir_enable, branch, addr_sel, flags_reg_enable;
    logic [DATA_W-1:0] ram_rdata;
    logic alu_zero, alu_neg, alu_uovf, alu_sovf;
    logic [ADDR_W-1:0] ram_addr, pc_out;
    decoded_instruction_type decoded_instruction;
    logic [1:0] a_addr, b_addr, c_addr;
    logic zero_op, neg_op, unsigned_overflow, signed_overflow;
`ifdef FETCH_ILLEGAL_TRAP_EN
    logic illegal_op;
`endif

    fetch_decode_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .pc_enable           (pc_enable),
        .ir_enable           (ir_enable),
        .branch              (branch),
        .addr_sel            (addr_sel),
        .flags_reg_enable    (flags_reg_enable),
        .ram_rdata           (ram_rdata),
        .alu_zero            (alu_zero),
        .alu_neg             (alu_neg),
        .alu_uovf            (alu_uovf),
        .alu_sovf            (alu_sovf),
        .ram_addr            (ram_addr),
        .pc_out              (pc_out),
        .decoded_instruction (decoded_instruction),
        .a_addr              (a_addr),
        .b_addr              (b_addr),
        .c_addr              (c_addr),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow)
`ifdef FETCH_ILLEGAL_TRAP_EN
        ,
        .illegal_op          (illegal_op)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         pc;
        logic [3:0] flags;
        logic [3:0] dec;
        logic [1:0] a, b, c;
        int         ram;
        logic       ill;
    } exp_t;

    exp_t sb_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int         m_pc;
    logic [15:0] m_ir;
    logic [3:0] m_flags;
    logic       m_ill;

    function automatic bit ref_legal(input logic [7:0] op);
        for (int i = 0; i < 16; i++) if (OP_CODE[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic decoded_instruction_type ref_dec(input logic [7:0] op);
        for (int i = 0; i < 16; i++) if (OP_CODE[i] == op) return OP_KIND[i];
`ifdef FETCH_ILLEGAL_TRAP_EN
        return I_HALT;
`else
        return I_NOP;
`endif
    endfunction

    task automatic ref_regs(input logic [15:0] ir, output logic [1:0] a, output logic [1:0] b,
                            output logic [1:0] c);
        decoded_instruction_type k = ref_dec(ir[15:8]);
        a = 2'd0; b = 2'd0; c = 2'd0;
        if (k == I_LOAD) c = ir[6:5];
        else if (k == I_STORE) a = ir[6:5];
        else if (k == I_MOVE) begin c = ir[3:2]; a = ir[1:0]; b = ir[1:0]; end
        else if (k == I_ADD || k == I_SUB || k == I_AND || k == I_OR) begin
            c = ir[5:4]; a = ir[3:2]; b = ir[1:0];
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; expected post-edge outputs go to the scoreboard.
    task automatic step(input bit pe, input bit ie, input bit br, input bit as, input bit fe,
                        input logic [15:0] rd, input logic [3:0] alu);
        exp_t e;
        logic [15:0] ir_old;
        @(negedge clk);
        pc_enable = pe; ir_enable = ie; branch = br; addr_sel = as; flags_reg_enable = fe;
        ram_rdata = rd;
        {alu_zero, alu_neg, alu_uovf, alu_sovf} = alu;
        ir_old = m_ir;
        if (ie) m_ir = rd;
        if (pe) m_pc = br ? int'(ir_old[4:0]) : (m_pc + 1) % 32;
        if (fe) m_flags = alu;
        if (!ref_legal(ir_old[15:8])) m_ill = 1'b1;
        e.pc    = m_pc;
        e.flags = m_flags;
        e.dec   = ref_dec(m_ir[15:8]);
        ref_regs(m_ir, e.a, e.b, e.c);
        e.ram   = as ? int'(m_ir[4:0]) : m_pc;
        e.ill   = m_ill;
        sb_q.push_back(e);
    endtask

    task automatic rand_step();
        logic [7:0] op;
        op = ($urandom_range(3) != 0) ? OP_CODE[$urandom_range(15)] : 8'($urandom);
        step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             {op, 8'($urandom)}, 4'($urandom));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_pc = 0; m_ir = '0; m_flags = '0; m_ill = 1'b0;
        check("reset_pc", 32'(pc_out), 32'd0);
        check("reset_ram_addr", 32'(ram_addr), 32'd0);
        check("reset_dec", 32'(decoded_instruction), 32'(I_NOP));
        check("reset_regs", {26'd0, a_addr, b_addr, c_addr}, 32'd0);
        check("reset_flags", {28'd0, zero_op, neg_op, unsigned_overflow, signed_overflow}, 32'd0);
`ifdef FETCH_ILLEGAL_TRAP_EN
        check("reset_illegal", 32'(illegal_op), 32'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("pc", 32'(pc_out), 32'(e.pc));
                check("ram_addr", 32'(ram_addr), 32'(e.ram));
                check("decoded", 32'(decoded_instruction), 32'(e.dec));
                check("a_addr", 32'(a_addr), 32'(e.a));
                check("b_addr", 32'(b_addr), 32'(e.b));
                check("c_addr", 32'(c_addr), 32'(e.c));
                check("flags", {28'd0, zero_op, neg_op, unsigned_overflow, signed_overflow},
                      32'(e.flags));
`ifdef FETCH_ILLEGAL_TRAP_EN
                check("illegal_op", 32'(illegal_op), 32'(e.ill));
`endif
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        pc_enable = 0; ir_enable = 0; branch = 0; addr_sel = 0; flags_reg_enable = 0;
        ram_rdata = '0; alu_zero = 0; alu_neg = 0; alu_uovf = 0; alu_sovf = 0;
        rst_n = 1'b0;
        #2;
        do_reset();

        repeat (3) step(1, 0, 0, 0, 0, 16'h0000, 4'h0);
        step(1, 1, 0, 0, 0, 16'hA11B, 4'h0);
        step(0, 0, 0, 0, 0, 16'h0000, 4'h0);
        step(0, 1, 0, 0, 0, 16'h0111, 4'h0);
        step(1, 0, 1, 0, 0, 16'h0000, 4'h0);
        step(0, 0, 1, 0, 0, 16'h0000, 4'h0);
        step(0, 1, 0, 0, 0, 16'h001F, 4'h0);
        step(1, 0, 1, 0, 0, 16'h0000, 4'h0);
        step(1, 0, 0, 0, 0, 16'h0000, 4'h0);
        step(0, 1, 0, 1, 0, 16'h8147, 4'h0);
        step(0, 0, 0, 1, 0, 16'h0000, 4'h0);
        step(0, 0, 0, 0, 0, 16'h0000, 4'h0);
        step(0, 0, 0, 0, 1, 16'h0000, 4'b1001);
        step(0, 0, 0, 0, 0, 16'h0000, 4'b0110);
        step(0, 1, 0, 0, 0, 16'h4200, 4'h0);
        step(0, 0, 0, 0, 0, 16'h0000, 4'h0);
        step(0, 1, 0, 0, 0, 16'hA11B, 4'h0);
        step(0, 0, 0, 0, 0, 16'h0000, 4'h0);

        repeat (400) rand_step();

        @(posedge clk);
        #2;
        do_reset();
        repeat (150) rand_step();

        @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
